// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit queue: FIFO of DEPTH bytes (fifo_en=1) or a single holding register (fifo_en=0).
// Latency: a write is visible on din/thre one edge later; a pop rising edge dequeues on the next edge.
// Backpressure: writes to a full queue are dropped and set sticky overrun; a same-cycle dequeue frees a slot.
module uart_tx_fifo_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          fifo_en,
   input  logic          tx_fifo_rst,
   input  logic          ier_thre,
   input  logic          irq_clr,
   input  logic          ovr_clr,
   input  logic          pop,
   input  logic          sreg_empty,
   output logic [7:0]    din,
   output logic          thre,
   output logic          temt,
   output logic [AW:0]   tx_level,
   output logic          overrun,
   output logic          thre_irq
);

   // Byte storage; deliberately not reset.
   logic [7:0]  mem [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          pop_d;
   logic          thre_d;
   logic          ier_d;
   // Previous fifo_en, used to detect a mode change. Resets to 0, so entering
   // FIFO mode straight out of reset costs one harmless flush of an empty queue.
   logic          fifo_en_d;

   logic [AW:0]   cap;
   logic          flush;
   logic          deq_req;
   logic          deq_ok;
   logic          room;
   logic          enq_ok;
   logic          drop;
   logic          irq_set;
   logic          irq_clear;

   // Queue control decode: capacity, flush, dequeue edge, room after same-cycle dequeue.
   always_comb begin
      cap       = fifo_en ? (AW+1)'(DEPTH) : (AW+1)'(1);
      flush     = tx_fifo_rst | (fifo_en ^ fifo_en_d);
      deq_req   = pop & ~pop_d;
      deq_ok    = deq_req & (count != '0);
      room      = (count < cap) | deq_ok;
      enq_ok    = wr_en & room & ~flush;
      drop      = wr_en & ~room & ~flush;
      // thre falling back to empty, or the enable rising while already empty.
      irq_set   = (~thre_d & thre) | (ier_thre & ~ier_d & thre);
      irq_clear = irq_clr | enq_ok;
   end

   // Pointer and occupancy update; flush overrides everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (deq_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (enq_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (enq_ok && !deq_ok) begin
            count <= count + 1'b1;
         end else if (deq_ok && !enq_ok) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage write for accepted bytes.
   always_ff @(posedge clk) begin
      if (enq_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Edge-detect history for pop, thre, ier_thre and fifo_en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pop_d     <= 1'b0;
         thre_d    <= 1'b1;
         ier_d     <= 1'b0;
         fifo_en_d <= 1'b0;
      end else begin
         pop_d     <= pop;
         thre_d    <= thre;
         ier_d     <= ier_thre;
         fifo_en_d <= fifo_en;
      end
   end

   // Sticky overrun: a dropped write wins over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (ovr_clr) begin
         overrun <= 1'b0;
      end
   end

   // THRE interrupt: held low while disabled, set beats clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thre_irq <= 1'b0;
      end else if (!ier_thre) begin
         thre_irq <= 1'b0;
      end else if (irq_set) begin
         thre_irq <= 1'b1;
      end else if (irq_clear) begin
         thre_irq <= 1'b0;
      end
   end

   // Status outputs, combinational from registered state.
   always_comb begin
      din      = mem[rd_ptr];
      thre     = (count == '0);
      temt     = thre & sreg_empty;
      tx_level = count;
   end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Runs a fixed linear sequence, then prints one summary line.
module tb_uart_tx_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       fifo_en;
   logic       tx_fifo_rst;
   logic       ier_thre;
   logic       irq_clr;
   logic       ovr_clr;
   logic       pop;
   logic       sreg_empty;
   logic [7:0] din;
   logic       thre;
   logic       temt;
   logic [4:0] tx_level;
   logic       overrun;
   logic       thre_irq;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_fifo_ctrl #(.DEPTH(16), .AW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .fifo_en     (fifo_en),
      .tx_fifo_rst (tx_fifo_rst),
      .ier_thre    (ier_thre),
      .irq_clr     (irq_clr),
      .ovr_clr     (ovr_clr),
      .pop         (pop),
      .sreg_empty  (sreg_empty),
      .din         (din),
      .thre        (thre),
      .temt        (temt),
      .tx_level    (tx_level),
      .overrun     (overrun),
      .thre_irq    (thre_irq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic flush_q();
      tx_fifo_rst = 1'b1;
      step();
      tx_fifo_rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; fifo_en = 1'b1; tx_fifo_rst = 1'b0;
      ier_thre = 1'b0; irq_clr = 1'b0; ovr_clr = 1'b0; pop = 1'b0; sreg_empty = 1'b0;

      // Reset state
      step(); step();
      chk("rst_thre", 32'(thre), 32'd1);
      chk("rst_temt", 32'(temt), 32'd0);
      chk("rst_level", 32'(tx_level), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_irq", 32'(thre_irq), 32'd0);
      rst = 1'b0;
      step(); step();
      sreg_empty = 1'b1;
      step();
      chk("idle_temt", 32'(temt), 32'd1);

      // First write
      wr(8'h55);
      chk("w1_thre", 32'(thre), 32'd0);
      chk("w1_din", 32'(din), 32'h55);
      chk("w1_level", 32'(tx_level), 32'd1);
      chk("w1_temt", 32'(temt), 32'd0);
      chk("w1_irq", 32'(thre_irq), 32'd0);

      // Fill to 16, then overflow
      flush_q();
      chk("fl_level", 32'(tx_level), 32'd0);
      for (int i = 1; i <= 16; i++) wr(8'(i));
      chk("full_level", 32'(tx_level), 32'd16);
      chk("full_ovr0", 32'(overrun), 32'd0);
      wr(8'hAA);
      chk("ovf_level", 32'(tx_level), 32'd16);
      chk("ovf_overrun", 32'(overrun), 32'd1);
      chk("ovf_din", 32'(din), 32'h01);
      ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);
      // Full with same-cycle dequeue: accepted
      pop = 1'b1; wr(8'hBB);
      chk("fullrw_level", 32'(tx_level), 32'd16);
      chk("fullrw_din", 32'(din), 32'h02);
      chk("fullrw_ovr", 32'(overrun), 32'd0);
      pop = 1'b0; step();

      // Long pop level: exactly one dequeue
      flush_q();
      wr(8'hA1); wr(8'hA2); wr(8'hA3);
      chk("p3_level", 32'(tx_level), 32'd3);
      pop = 1'b1;
      for (int i = 0; i < 32; i++) step();
      chk("plong_level", 32'(tx_level), 32'd2);
      chk("plong_din", 32'(din), 32'hA2);
      pop = 1'b0; step();
      pop = 1'b1; step();
      chk("p2_level", 32'(tx_level), 32'd1);
      chk("p2_din", 32'(din), 32'hA3);
      pop = 1'b0; step();

      // Holding-register mode
      fifo_en = 1'b0; step();
      chk("mode_flush", 32'(tx_level), 32'd0);
      wr(8'h11); wr(8'h22);
      chk("hr_din", 32'(din), 32'h11);
      chk("hr_overrun", 32'(overrun), 32'd1);
      chk("hr_level", 32'(tx_level), 32'd1);
      pop = 1'b1; wr(8'h33);
      chk("hr_rw_din", 32'(din), 32'h33);
      chk("hr_rw_level", 32'(tx_level), 32'd1);
      pop = 1'b0;
      ovr_clr = 1'b1; step(); ovr_clr = 1'b0;

      // THRE interrupt
      fifo_en = 1'b1; step();
      wr(8'h5A);
      ier_thre = 1'b1; step();
      chk("irq_busy", 32'(thre_irq), 32'd0);
      pop = 1'b1; step();
      chk("irq_thre", 32'(thre), 32'd1);
      chk("irq_early", 32'(thre_irq), 32'd0);
      step();
      chk("irq_set", 32'(thre_irq), 32'd1);
      irq_clr = 1'b1; step(); irq_clr = 1'b0;
      chk("irq_clr", 32'(thre_irq), 32'd0);
      pop = 1'b0;
      ier_thre = 1'b0; step();
      ier_thre = 1'b1; step();
      chk("irq_ier_rise", 32'(thre_irq), 32'd1);
      wr(8'h66);
      chk("irq_wr_clr", 32'(thre_irq), 32'd0);
      chk("irq_wr_level", 32'(tx_level), 32'd1);
      ier_thre = 1'b0; step();

      // Flush with simultaneous write
      flush_q();
      for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
      chk("f5_level", 32'(tx_level), 32'd5);
      tx_fifo_rst = 1'b1; wr(8'h77); tx_fifo_rst = 1'b0;
      chk("fw_level", 32'(tx_level), 32'd0);
      chk("fw_thre", 32'(thre), 32'd1);
      chk("fw_overrun", 32'(overrun), 32'd0);
      wr(8'h88);
      chk("fw_head", 32'(din), 32'h88);
      chk("fw_head_level", 32'(tx_level), 32'd1);

      // Pop on an empty queue is ignored
      pop = 1'b1; step();
      chk("pe_level0", 32'(tx_level), 32'd0);
      pop = 1'b0; step();
      pop = 1'b1; step();
      chk("pe_ignored", 32'(tx_level), 32'd0);
      pop = 1'b0;
      wr(8'h99);
      chk("pe_din", 32'(din), 32'h99);
      chk("pe_level", 32'(tx_level), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
Transmit-side controller that sits between the CPU register interface and the UART transmit serializer. It buffers host writes to THR in a TX FIFO, or in a single holding register in 16450 mode. It presents the head byte and THRE to the serializer and consumes the serializer's pop strobe. It also generates TEMT, FIFO level, overrun status and the THRE interrupt.

Parameters:
DEPTH, 16, TX FIFO depth in entries; power of two, at least 2
AW, 4, pointer width, log2(DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
wr_en  in  1  one-cycle host write strobe to THR
wr_data  in  8  byte to enqueue
fifo_en  in  1  FCR[0]; 1 = FIFO mode, 0 = single holding register
tx_fifo_rst  in  1  FCR[2] pulse; flushes the FIFO synchronously
ier_thre  in  1  THRE interrupt enable
irq_clr  in  1  one-cycle pulse; clears thre_irq (IIR read)
ovr_clr  in  1  one-cycle pulse; clears overrun
pop  in  1  serializer read request; a level that may stay high for many clk cycles
sreg_empty  in  1  serializer shift register empty
din  out  8  head-of-queue byte to the serializer
thre  out  1  1 when the queue is empty
temt  out  1  thre & sreg_empty
tx_level  out  AW+1  current occupancy, 0..DEPTH
overrun  out  1  sticky; set when a write is dropped
thre_irq  out  1  THRE interrupt request

Behaviour:
- Reset values: rd_ptr=0, wr_ptr=0, count=0, pop_d=0, overrun=0, thre_irq=0, thre_d=1. Outputs at reset: thre=1, temt=0 (sreg_empty is 0 from the serializer in reset), tx_level=0, din=mem[0]. FIFO storage is not reset.
- Capacity: cap = DEPTH when fifo_en=1, else cap = 1. Mode change (either edge of fifo_en) flushes the queue exactly like tx_fifo_rst.
- Pop detection: pop_d is a registered copy of pop; deq_req = pop & ~pop_d. Exactly one dequeue per rising edge of pop, regardless of how long pop stays high.
- Dequeue: if deq_req and count>0, then rd_ptr+1 (wraps modulo DEPTH) and count-1. If deq_req and count==0, ignore it; no pointer change.
- Enqueue: if wr_en and there is room, then mem[wr_ptr]=wr_data, wr_ptr+1 (wraps), count+1. Room is evaluated after the same-cycle dequeue: accepted if count<cap, or if count==cap and a valid dequeue happens in the same cycle.
- Full write with no dequeue: data is dropped, pointers are unchanged, overrun is set to 1 on the next edge. ovr_clr clears overrun; if a drop and ovr_clr occur in the same cycle, set wins.
- Simultaneous enqueue and dequeue when 0<count<=cap: count is unchanged and both pointers advance.
- din: combinational from mem[rd_ptr], valid whenever thre=0. When count>0 it is stable until the cycle after a valid dequeue.
- thre = (count==0); tx_level = count; both combinational from registers.
- Flush (tx_fifo_rst, or a mode change): rd_ptr=wr_ptr=0 and count=0 on the next edge. A write in the same cycle is discarded and does not set overrun. The serializer byte already loaded is not affected.
- THRE interrupt: thre_irq is set on the edge where thre_d=0 and thre=1 while ier_thre=1. It is also set on the edge where ier_thre rises while thre=1. It is cleared by irq_clr or by any accepted write. Set has priority over clear in the same cycle. When ier_thre=0, thre_irq is forced to 0.
- Latency: wr_en at edge N gives thre=0 and the new din after edge N. A pop rising edge sampled at edge N advances rd_ptr after edge N.

Test Plan:
- Reset, then write 0x55 with fifo_en=1 -> after one clk thre=0, din=0x55, tx_level=1, temt=0. No IRQ (ier_thre=0).
- fifo_en=1, write 0x01..0x10 (16 bytes), then write 0xAA -> tx_level=16, 0xAA dropped, overrun=1. ovr_clr -> overrun=0.
- Hold pop high for 32 clks with tx_level=3 -> exactly one dequeue, tx_level=2, din moves to the second byte. A second pop rising edge gives tx_level=1.
- fifo_en=0, write 0x11 then 0x22 with no pop -> din=0x11, overrun=1. A pop edge and a write of 0x33 in the same cycle -> din=0x33, tx_level=1.
- ier_thre=1, one byte queued, pop edge -> thre=1 and thre_irq=1 one clk later. irq_clr -> thre_irq=0. Toggling ier_thre 0->1 while empty -> thre_irq=1.
- 5 bytes queued, pulse tx_fifo_rst together with wr_en (0x77) -> tx_level=0, thre=1, overrun unchanged. Then wr_ptr=0, and the next write lands as the head.
